// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM bank.
// Holds the output-mode encoding, the parameter defaults used by pwm_bank and
// pwm_channel, and the helper that sizes the channel-select index.
package pwm_pkg;

    localparam int DEF_WIDTH    = 16;
    localparam int DEF_CHANNELS = 4;
    localparam int DEF_PRESC_W  = 8;

    // Output modulation style latched at each boundary load.
    typedef enum logic {
        MODE_CMP = 1'b0,   // plain compare PWM
        MODE_BAM = 1'b1    // binary-weighted (bit-angle) modulation
    } pwm_mode_e;

    // Width of the channel index port; a single channel still gets one bit.
    function automatic int ch_idx_w(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// One output channel of the PWM bank: decodes the shared counter against this
// channel's active duty in either compare or BAM mode and registers the result.
//
// Ports
//   clock     rising-edge clock
//   reset_n   asynchronous active-low reset
//   cnt       shared period counter
//   duty      active (committed) duty for this channel
//   mode_sel  active modulation mode
//   out       registered modulated output (one clock behind cnt)
module pwm_channel
    import pwm_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] cnt,
    input  logic [WIDTH-1:0] duty,
    input  pwm_mode_e        mode_sel,
    output logic             out
);

    logic bam_bit;
    logic out_next;
    logic out_reg;

    // BAM: counts in [2^k, 2^(k+1)) carry duty bit k, so the slot is chosen by
    // the highest set bit of cnt. cnt == 0 has no set bit and stays low, which
    // makes the high time per period exactly equal to the duty value.
    always_comb begin
        bam_bit = 1'b0;
        for (int k = 0; k < WIDTH; k++) begin
            if (cnt[k]) begin
                bam_bit = duty[k];
            end
        end
    end

    always_comb begin
        out_next = (cnt < duty);
        if (mode_sel == MODE_BAM) begin
            out_next = bam_bit;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_reg <= 1'b0;
        end else begin
            out_reg <= out_next;
        end
    end

    assign out = out_reg;

endmodule

// File: rtl/pwm_bank.sv
// Bank of CHANNELS PWM outputs sharing one prescaler and period counter.
// Duty values are written into per-channel shadow registers at any time and
// only reach the outputs when a commit is honoured at a period boundary, so an
// output never changes its duty in the middle of a period.
//
// Ports
//   clock         rising-edge clock
//   reset_n       asynchronous active-low reset
//   duty_data     duty value for a shadow write
//   duty_ch       channel index for the shadow write (out-of-range ignored)
//   duty_we       shadow write strobe
//   commit        load shadows and mode at the next boundary
//   mode          0 = compare PWM, 1 = BAM; captured at the boundary load
//   prescale      counter advances once every prescale+1 clocks
//   out           registered channel outputs
//   period_start  one-clock pulse while the counter sits at 0 after a wrap
//   pending       commit requested but not yet loaded
module pwm_bank
    import pwm_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int PRESC_W  = DEF_PRESC_W
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic [WIDTH-1:0]                duty_data,
    input  logic [ch_idx_w(CHANNELS)-1:0]   duty_ch,
    input  logic                            duty_we,
    input  logic                            commit,
    input  logic                            mode,
    input  logic [PRESC_W-1:0]              prescale,
    output logic [CHANNELS-1:0]             out,
    output logic                            period_start,
    output logic                            pending
);

    localparam int CH_W = ch_idx_w(CHANNELS);

    logic [PRESC_W-1:0] presc_reg;
    logic [WIDTH-1:0]   cnt_reg;
    logic               period_start_reg;
    logic               pending_reg;
    pwm_mode_e          mode_reg;

    logic tick;
    logic boundary;
    logic load;

    // Greater-or-equal rather than equality: if prescale is lowered below the
    // running prescaler value, the next compare fires at once instead of
    // waiting for the prescaler to wrap through its full range.
    assign tick     = (presc_reg >= prescale);
    assign boundary = tick && (cnt_reg == '1);
    // A commit arriving in the boundary cycle itself is loaded right there.
    assign load     = boundary && (pending_reg || commit);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            presc_reg        <= '0;
            cnt_reg          <= '0;
            period_start_reg <= 1'b0;
            pending_reg      <= 1'b0;
            mode_reg         <= MODE_CMP;
        end else begin
            presc_reg        <= tick ? '0 : presc_reg + 1'b1;
            period_start_reg <= boundary;
            if (tick) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
            if (load) begin
                pending_reg <= 1'b0;
                mode_reg    <= pwm_mode_e'(mode);
            end else if (commit) begin
                pending_reg <= 1'b1;
            end
        end
    end

    assign period_start = period_start_reg;
    assign pending      = pending_reg;

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic [WIDTH-1:0] shadow_reg;
            logic [WIDTH-1:0] active_reg;
            logic             wr;

            // Indices with no matching channel select nothing and are dropped.
            assign wr = duty_we && (duty_ch == CH_W'(gi));

            // Non-blocking update means a load coinciding with a write copies
            // the shadow value from before that write.
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    shadow_reg <= '0;
                    active_reg <= '0;
                end else begin
                    if (wr) begin
                        shadow_reg <= duty_data;
                    end
                    if (load) begin
                        active_reg <= shadow_reg;
                    end
                end
            end

            pwm_channel #(
                .WIDTH (WIDTH)
            ) u_channel (
                .clock    (clock),
                .reset_n  (reset_n),
                .cnt      (cnt_reg),
                .duty     (active_reg),
                .mode_sel (mode_reg),
                .out      (out[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_pwm_bank.sv
// Self-checking bench for pwm_bank (WIDTH=4). Two builds run side by side on
// the same stimulus: CHANNELS=2 (1-bit index) and CHANNELS=3 (2-bit index).
// The 2-channel build cannot address channels 2/3, so its write strobe is
// gated to indices 0/1 here. A behavioural model tracks both builds.
module tb_pwm_bank;

    logic       clock;
    logic       reset_n;
    logic [3:0] duty_data;
    logic [1:0] duty_ch;
    logic       duty_we;
    logic       commit;
    logic       mode;
    logic [7:0] prescale;

    logic [1:0] out2;
    logic       ps2, pend2;
    logic [2:0] out3;
    logic       ps3, pend3;

    int tests_run;
    int tests_failed;

    pwm_bank #(.WIDTH(4), .CHANNELS(2), .PRESC_W(8)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .duty_data    (duty_data),
        .duty_ch      (duty_ch[0]),
        .duty_we      (duty_we && !duty_ch[1]),
        .commit       (commit),
        .mode         (mode),
        .prescale     (prescale),
        .out          (out2),
        .period_start (ps2),
        .pending      (pend2)
    );

    pwm_bank #(.WIDTH(4), .CHANNELS(3), .PRESC_W(8)) dut3 (
        .clock        (clock),
        .reset_n      (reset_n),
        .duty_data    (duty_data),
        .duty_ch      (duty_ch),
        .duty_we      (duty_we),
        .commit       (commit),
        .mode         (mode),
        .prescale     (prescale),
        .out          (out3),
        .period_start (ps3),
        .pending      (pend3)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- behavioural reference model ----------------
    // Expected output bit for counter value c, duty d and mode md.
    function automatic logic exp_bit(input int c, input int d, input logic md);
        int k;
        if (md == 1'b0) return (c < d);
        if (c == 0) return 1'b0;
        k = 0;
        while ((2 << k) <= c) k++;   // c lies in [2^k, 2^(k+1))
        return d[k];
    endfunction

    int         m_div;
    int         m_cnt;
    logic       m_pending;
    logic       m_ps;
    logic       m_mode;
    int         m_shadow [3];
    int         m_active [3];
    logic [2:0] m_out;
    logic       m_tick, m_bound, m_load;

    assign m_tick  = (m_div >= int'(prescale));
    assign m_bound = m_tick && (m_cnt == 15);
    assign m_load  = m_bound && (m_pending || commit);

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_div     <= 0;
            m_cnt     <= 0;
            m_pending <= 1'b0;
            m_ps      <= 1'b0;
            m_mode    <= 1'b0;
            m_out     <= '0;
            for (int i = 0; i < 3; i++) begin
                m_shadow[i] <= 0;
                m_active[i] <= 0;
            end
        end else begin
            for (int i = 0; i < 3; i++) m_out[i] <= exp_bit(m_cnt, m_active[i], m_mode);
            m_ps  <= m_bound;
            m_div <= m_tick ? 0 : m_div + 1;
            if (m_tick) m_cnt <= (m_cnt + 1) % 16;
            if (m_load) begin
                for (int i = 0; i < 3; i++) m_active[i] <= m_shadow[i];
                m_mode    <= mode;
                m_pending <= 1'b0;
            end else if (commit) begin
                m_pending <= 1'b1;
            end
            for (int i = 0; i < 3; i++)
                if (duty_we && duty_ch == i) m_shadow[i] <= int'(duty_data);
        end
    end

    // ---------------- stimulus helpers (no checking) ----------------
    // All helpers are entered and left right after a falling edge.
    task automatic write_duty(input int ch, input int val);
        duty_ch   = 2'(ch);
        duty_data = 4'(val);
        duty_we   = 1'b1;
        @(negedge clock);
        duty_we   = 1'b0;
    endtask

    task automatic do_commit(input logic md);
        commit = 1'b1;
        mode   = md;
        @(negedge clock);
        commit = 1'b0;
    endtask

    task automatic wait_model_ps();
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!m_ps && n < 200);
        if (!m_ps) begin
            tests_run++; tests_failed++;
            $display("FAIL wait_period_start: timed out after %0d clocks, required a boundary", n);
        end
    endtask

    task automatic wait_model_cnt(input int c);
        int n = 0;
        while (m_cnt != c && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (m_cnt != c) begin
            tests_run++; tests_failed++;
            $display("FAIL wait_cnt: timed out, cnt %0d required %0d", m_cnt, c);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        duty_data = '0; duty_ch = '0; duty_we = 1'b0;
        commit = 1'b0; mode = 1'b0; prescale = '0;
        repeat (3) @(negedge clock);
        tests_run++; if (out2 !== 2'b00) begin tests_failed++; $display("FAIL reset_out2: got %b required 00", out2); end
        tests_run++; if (out3 !== 3'b000) begin tests_failed++; $display("FAIL reset_out3: got %b required 000", out3); end
        tests_run++; if (ps2 !== 1'b0 || ps3 !== 1'b0) begin tests_failed++; $display("FAIL reset_period_start: got %b/%b required 0/0", ps2, ps3); end
        tests_run++; if (pend2 !== 1'b0 || pend3 !== 1'b0) begin tests_failed++; $display("FAIL reset_pending: got %b/%b required 0/0", pend2, pend3); end
        reset_n = 1'b1;
        @(negedge clock);
        tests_run++; if (ps2 !== 1'b0) begin tests_failed++; $display("FAIL reset_first_clock_ps: got %b required 0", ps2); end
        tests_run++; if (out2 !== 2'b00) begin tests_failed++; $display("FAIL reset_first_clock_out: got %b required 00", out2); end
    endtask

    task automatic test_compare();
        int highs = 0;
        prescale = 8'd0;
        write_duty(0, 5);
        do_commit(1'b0);
        tests_run++; if (pend2 !== m_pending) begin tests_failed++; $display("FAIL cmp_pending: got %b required %b", pend2, m_pending); end
        wait_model_ps();
        tests_run++; if (ps2 !== 1'b1) begin tests_failed++; $display("FAIL cmp_period_start: got %b required 1", ps2); end
        for (int j = 0; j < 16; j++) begin
            @(negedge clock);
            if (out2[0]) highs++;
            tests_run++; if (out2[0] !== (j < 5)) begin tests_failed++; $display("FAIL cmp_wave: clock %0d got %b required %b", j, out2[0], (j < 5)); end
            tests_run++; if (out2 !== m_out[1:0]) begin tests_failed++; $display("FAIL cmp_model: clock %0d got %b required %b", j, out2, m_out[1:0]); end
            tests_run++; if (ps2 !== (j == 15)) begin tests_failed++; $display("FAIL cmp_ps_spacing: clock %0d got %b required %b", j, ps2, (j == 15)); end
        end
        tests_run++; if (highs != 5) begin tests_failed++; $display("FAIL cmp_high_count: got %0d required 5", highs); end
    endtask

    task automatic test_bam();
        logic [15:0] pat = 16'hFF0C;   // high at counts 2,3 and 8..15
        int highs = 0;
        write_duty(1, 4'b1010);
        do_commit(1'b1);
        wait_model_ps();
        for (int j = 0; j < 16; j++) begin
            @(negedge clock);
            if (out2[1]) highs++;
            tests_run++; if (out2[1] !== pat[j]) begin tests_failed++; $display("FAIL bam_wave: cnt %0d got %b required %b", j, out2[1], pat[j]); end
            tests_run++; if (out3 !== m_out) begin tests_failed++; $display("FAIL bam_model: cnt %0d got %b required %b", j, out3, m_out); end
        end
        tests_run++; if (highs != 10) begin tests_failed++; $display("FAIL bam_high_count: got %0d required 10", highs); end
    endtask

    task automatic test_glitch_free();
        int highs = 0;
        write_duty(0, 3);
        do_commit(1'b0);
        wait_model_ps();
        // Sample j shows out for count j while the counter already holds j+1.
        for (int j = 0; j < 16; j++) begin
            @(negedge clock);
            duty_we = 1'b0;
            commit  = 1'b0;
            if (out2[0]) highs++;
            tests_run++; if (pend2 !== (j >= 7 && j <= 14)) begin tests_failed++; $display("FAIL glitch_pending: clock %0d got %b required %b", j, pend2, (j >= 7 && j <= 14)); end
            if (j == 6) begin
                duty_ch = 2'd0; duty_data = 4'd12; duty_we = 1'b1; commit = 1'b1;
            end
        end
        tests_run++; if (highs != 3) begin tests_failed++; $display("FAIL glitch_current_period: got %0d high clocks required 3", highs); end
        highs = 0;
        for (int j = 0; j < 16; j++) begin
            @(negedge clock);
            if (out2[0]) highs++;
        end
        tests_run++; if (highs != 12) begin tests_failed++; $display("FAIL glitch_next_period: got %0d high clocks required 12", highs); end
    endtask

    task automatic test_prescaler();
        int highs = 0;
        prescale = 8'd2;
        wait_model_ps();
        for (int k = 1; k <= 48; k++) begin
            @(negedge clock);
            if (out2[0]) highs++;
            tests_run++; if (ps2 !== (k == 48)) begin tests_failed++; $display("FAIL presc_period: clock %0d got %b required %b", k, ps2, (k == 48)); end
            tests_run++; if (out2 !== m_out[1:0]) begin tests_failed++; $display("FAIL presc_model: clock %0d got %b required %b", k, out2, m_out[1:0]); end
        end
        tests_run++; if (highs != 36) begin tests_failed++; $display("FAIL presc_high_count: got %0d required 36", highs); end
        prescale = 8'd0;
    endtask

    task automatic test_edges();
        int h0 = 0, h1 = 0, h2 = 0;
        write_duty(0, 0);
        write_duty(1, 15);
        write_duty(2, 9);
        write_duty(3, 7);          // no channel 3 on either build
        wait_model_cnt(15);
        commit = 1'b1; mode = 1'b0;
        @(negedge clock);
        commit = 1'b0;
        tests_run++; if (ps2 !== 1'b1) begin tests_failed++; $display("FAIL edge_coincident_ps: got %b required 1", ps2); end
        for (int j = 0; j < 16; j++) begin
            @(negedge clock);
            if (out2[0]) h0++;
            if (out2[1]) h1++;
            if (out3[2]) h2++;
            tests_run++; if (pend2 !== 1'b0 || pend3 !== 1'b0) begin tests_failed++; $display("FAIL edge_pending_low: clock %0d got %b/%b required 0/0", j, pend2, pend3); end
            if (j == 15) begin
                tests_run++; if (out2[1] !== 1'b0) begin tests_failed++; $display("FAIL edge_duty15_low_slot: got %b required 0", out2[1]); end
            end
        end
        tests_run++; if (h0 != 0) begin tests_failed++; $display("FAIL edge_duty0: got %0d high clocks required 0", h0); end
        tests_run++; if (h1 != 15) begin tests_failed++; $display("FAIL edge_duty15: got %0d high clocks required 15", h1); end
        tests_run++; if (h2 != 9) begin tests_failed++; $display("FAIL edge_ch2_write: got %0d high clocks required 9", h2); end
        wait_model_cnt(9);
        tests_run++; if (out2[1] !== 1'b1) begin tests_failed++; $display("FAIL edge_pre_reset_out: got %b required 1", out2[1]); end
        reset_n = 1'b0;
        #1;
        tests_run++; if (out2 !== 2'b00 || out3 !== 3'b000) begin tests_failed++; $display("FAIL edge_async_reset_out: got %b/%b required 00/000", out2, out3); end
        tests_run++; if (ps2 !== 1'b0 || pend2 !== 1'b0) begin tests_failed++; $display("FAIL edge_async_reset_flags: got %b/%b required 0/0", ps2, pend2); end
        @(negedge clock);
        reset_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clock);
            tests_run++; if (ps2 !== (k == 16)) begin tests_failed++; $display("FAIL edge_restart_from_0: clock %0d got %b required %b", k, ps2, (k == 16)); end
            tests_run++; if (out2 !== 2'b00) begin tests_failed++; $display("FAIL edge_restart_out: clock %0d got %b required 00", k, out2); end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 900; n++) begin
            @(negedge clock);
            tests_run++; if (out2 !== m_out[1:0]) begin tests_failed++; $display("FAIL rand_out2: cycle %0d got %b required %b", n, out2, m_out[1:0]); end
            tests_run++; if (out3 !== m_out) begin tests_failed++; $display("FAIL rand_out3: cycle %0d got %b required %b", n, out3, m_out); end
            tests_run++; if (ps2 !== m_ps || ps3 !== m_ps) begin tests_failed++; $display("FAIL rand_period_start: cycle %0d got %b/%b required %b", n, ps2, ps3, m_ps); end
            tests_run++; if (pend2 !== m_pending || pend3 !== m_pending) begin tests_failed++; $display("FAIL rand_pending: cycle %0d got %b/%b required %b", n, pend2, pend3, m_pending); end
            duty_we   = ($urandom_range(0, 2) == 0);
            duty_ch   = 2'($urandom_range(0, 3));
            duty_data = 4'($urandom);
            commit    = ($urandom_range(0, 7) == 0);
            mode      = 1'($urandom);
            if (n % 150 == 0) prescale = 8'($urandom_range(0, 2));
        end
        duty_we = 1'b0;
        commit  = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_compare();
        test_bam();
        test_glitch_free();
        test_prescaler();
        test_edges();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
